clkdiv_sched: RTL and testbench

- Run-time controller for the even-ratio clock divider datapath.
- Accepts divide-ratio requests over a valid/ready handshake and produces one divided output clock.
- Applies a new ratio only at a full output-period boundary, so no runt pulses occur on a ratio change.
- Sits between the config/CSR logic and any consumer of the divided clock. Also exports a per-period strobe for downstream schedulers.

---
 rtl/clkdiv_pkg.sv | 5 +
 rtl/clkdiv_core.sv | 46 ++++
 rtl/clkdiv_sched.sv | 84 ++++++++
 tb/tb_clkdiv_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and default width for the clock-divider scheduler.
package clkdiv_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_e;
   localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: period counter owning cnt, the active half-period, div_out and period_done.
module clkdiv_core
   import clkdiv_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load_i,
   input  logic [CNT_W-1:0] half_i,
   input  logic             stop_i,
   output logic             div_o,
   output logic             period_done_o,
   output logic             boundary_o
);
   localparam logic [CNT_W:0] ONE = 1;
   logic [CNT_W:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic             div_q, div_d, pd_q, pd_d;
   assign boundary_o = (cnt_q != '0) && (cnt_q == {act_q, 1'b0});
   // A zero count with a nonzero ratio means a held-off period is free to start.
   always_comb begin
      act_d = load_i ? half_i : act_q;
      cnt_d = stop_i              ? '0 :
              load_i              ? ((half_i != '0) ? ONE : '0) :
              (cnt_q == '0)       ? ((act_q != '0) ? ONE : '0) :
              boundary_o          ? ONE : cnt_q + ONE;
      div_d = (cnt_d != '0) && (cnt_d <= {1'b0, act_d});
      pd_d  = (cnt_d != '0) && (cnt_d == {act_d, 1'b0});
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         act_q <= '0;
         div_q <= 1'b0;
         pd_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
         div_q <= div_d;
         pd_q  <= pd_d;
      end
   end
   assign div_o         = div_q;
   assign period_done_o = pd_q;
endmodule

// File: rtl/clkdiv_sched.sv
// clkdiv_sched: ratio handshake and FSM that retimes ratio changes to output-period boundaries.
// Optional restart input enabled by defining CLKDIV_SCHED_RESTART_EN.
module clkdiv_sched
   import clkdiv_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
`ifdef CLKDIV_SCHED_RESTART_EN
   input  logic             restart,
`endif
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             div_out,
   output logic             busy,
   output logic             period_done
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] pend_q, pend_d, half;
   logic             busy_q, load, rs, boundary, accept;
`ifdef CLKDIV_SCHED_RESTART_EN
   assign rs = restart && (state_q != IDLE);
`else
   assign rs = 1'b0;
`endif
   assign cfg_ready = (state_q != PEND) && !rs;
   assign accept    = cfg_valid && cfg_ready;
   // A zero half-period loaded into the core stops it, so stop and ratio change share one path.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      load    = 1'b0;
      half    = cfg_half;
      if (rs) begin
         load    = (state_q == PEND);
         half    = pend_q;
         state_d = (state_q == PEND && pend_q == '0) ? IDLE : RUN;
      end else begin
         unique case (state_q)
            IDLE: if (accept && cfg_half != '0) begin
               load    = 1'b1;
               state_d = RUN;
            end
            RUN: if (accept && boundary) begin
               load    = 1'b1;
               state_d = (cfg_half != '0) ? RUN : IDLE;
            end else if (accept) begin
               pend_d  = cfg_half;
               state_d = PEND;
            end
            PEND: if (boundary) begin
               load    = 1'b1;
               half    = pend_q;
               state_d = (pend_q != '0) ? RUN : IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         pend_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         busy_q  <= (state_d != IDLE);
      end
   end
   assign busy = busy_q;
   clkdiv_core #(.CNT_W(CNT_W)) u_core (
      .clk          (clk),
      .resetn       (resetn),
      .load_i       (load),
      .half_i       (half),
      .stop_i       (rs),
      .div_o        (div_out),
      .period_done_o(period_done),
      .boundary_o   (boundary)
   );
endmodule

// File: tb/tb_clkdiv_sched.sv
// tb_clkdiv_sched: randomized and directed checks of clkdiv_sched against a period-level reference model.
module tb_clkdiv_sched;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [3:0] cfg_half = 4'd0;
   logic       restart_in = 1'b0;
   logic       cfg_ready, div_out, busy, period_done;
   logic [3:0] obs;
   int         errors = 0;
   int         checks = 0;
   bit         m_run, m_held, m_pv;
   int         m_h, m_pos, m_ph;

   always #5 clk = ~clk;

   clkdiv_sched #(.CNT_W(4)) dut (
      .clk        (clk),
      .resetn     (resetn),
`ifdef CLKDIV_SCHED_RESTART_EN
      .restart    (restart_in),
`endif
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_half   (cfg_half),
      .div_out    (div_out),
      .busy       (busy),
      .period_done(period_done)
   );

   task automatic m_reset();
      m_run = 0; m_held = 0; m_pv = 0; m_h = 0; m_pos = 0; m_ph = 0;
   endtask

   // Make ratio x the active one from the start of a fresh period; zero means stopped.
   task automatic use_h(input int x);
      m_run = (x != 0);
      m_h   = x;
      m_pos = 0;
      m_pv  = 0;
   endtask

   // One clock edge of the reference: m_pos is the 0-based position inside a 2*m_h period.
   task automatic m_step(input bit v, input int h, input bit r);
      bit acc;
      acc = v && !m_pv && !(r && m_run);
      if (r && m_run) begin
         m_held = 1;
         if (m_pv) use_h(m_ph);
         if (!m_run) m_held = 0;
      end else if (!m_run) begin
         if (acc && h != 0) use_h(h);
      end else if (m_held) begin
         m_held = 0;
         m_pos  = 0;
         if (acc) begin m_pv = 1; m_ph = h; end
      end else if (m_pos == 2 * m_h - 1) begin
         if (acc) use_h(h);
         else if (m_pv) use_h(m_ph);
         else m_pos = 0;
      end else begin
         m_pos++;
         if (acc) begin m_pv = 1; m_ph = h; end
      end
   endtask

   function automatic logic [3:0] exp_vec();
      bit act;
      act = m_run && !m_held;
      return {!m_pv && !(restart_in && m_run), m_run, act && m_pos < m_h, act && m_pos == 2 * m_h - 1};
   endfunction

   task automatic tick(input bit v, input logic [3:0] h);
      cfg_valid = v;
      cfg_half  = h;
      @(posedge clk);
      m_step(v, int'(h), restart_in);
      #1;
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      m_reset();
      #12;
      obs = {cfg_ready, busy, div_out, period_done};
      checks++;
      if (obs !== 4'b1000) begin errors++; $display("FAIL reset_state got=%b exp=1000", obs); end
      @(posedge clk); #1 resetn = 1'b1;
   endtask

   task automatic test_div4();
      tick(1, 4'd2);
      for (int i = 0; i < 12; i++) begin
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== {1'b1, 1'b1, 1'((i % 4) < 2), 1'((i % 4) == 3)}) begin
            errors++; $display("FAIL div4_pattern cyc=%0d got=%b exp=%b", i, obs, {2'b11, 1'((i % 4) < 2), 1'((i % 4) == 3)});
         end
         tick(0, 4'd0);
      end
   endtask

   task automatic wait_pos(input int p, input string name);
      int n;
      n = 0;
      while (m_pos != p && n < 40) begin tick(0, 4'd0); n++; end
      checks++;
      if (m_pos != p) begin errors++; $display("FAIL %s_timeout got_pos=%0d exp_pos=%0d", name, m_pos, p); end
   endtask

   task automatic run_model(input int n, input string name);
      for (int i = 0; i < n; i++) begin
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, obs, exp_vec()); end
         tick(0, 4'd0);
      end
   endtask

   task automatic test_change();
      wait_pos(1, "change");
      tick(1, 4'd3);
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL change_ready got=%b exp=0", cfg_ready); end
      run_model(16, "change");
   endtask

   task automatic test_stop();
      wait_pos(5, "stop_sync");
      tick(1, 4'd1);
      run_model(6, "stop_h1");
      tick(1, 4'd0);
      run_model(6, "stop");
      obs = {cfg_ready, busy, div_out, period_done};
      checks++;
      if (obs !== 4'b1000) begin errors++; $display("FAIL stop_idle got=%b exp=1000", obs); end
   endtask

   task automatic test_boundary();
      tick(1, 4'd2);
      wait_pos(3, "boundary");
      tick(1, 4'd1);
      for (int i = 0; i < 8; i++) begin
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== {2'b11, 1'((i % 2) == 0), 1'((i % 2) == 1)}) begin
            errors++; $display("FAIL boundary cyc=%0d got=%b exp=%b", i, obs, {2'b11, 1'((i % 2) == 0), 1'((i % 2) == 1)});
         end
         tick(0, 4'd0);
      end
   endtask

   task automatic start_h3_pos1(input string name);
      int n;
      n = 0;
      while (!(m_run && !m_pv && m_h == 3 && m_pos == 1) && n < 60) begin
         tick(!(m_run && m_h == 3), 4'd3);
         n++;
      end
      checks++;
      if (!(m_run && m_h == 3 && m_pos == 1)) begin errors++; $display("FAIL %s_start_timeout got_h=%0d exp_h=3", name, m_h); end
   endtask

   task automatic test_async_reset();
      start_h3_pos1("areset");
      checks++;
      if (div_out !== 1'b1) begin errors++; $display("FAIL areset_pre got=%b exp=1", div_out); end
      #2 resetn = 1'b0;
      #1;
      m_reset();
      obs = {cfg_ready, busy, div_out, period_done};
      checks++;
      if (obs !== 4'b1000) begin errors++; $display("FAIL areset_immediate got=%b exp=1000", obs); end
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(0, 4'd0);
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== 4'b1000) begin errors++; $display("FAIL areset_after cyc=%0d got=%b exp=1000", i, obs); end
      end
   endtask

   task automatic test_random();
      bit         v;
      logic [3:0] h;
      for (int i = 0; i < 600; i++) begin
         v = ($urandom % 6) == 0;
         h = (($urandom % 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
`ifdef CLKDIV_SCHED_RESTART_EN
         restart_in = ($urandom % 25) == 0;
`endif
         tick(v, h);
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp_vec()); end
      end
      restart_in = 1'b0;
      #0;
   endtask

`ifdef CLKDIV_SCHED_RESTART_EN
   task automatic test_restart();
      start_h3_pos1("restart");
      restart_in = 1'b1;
      tick(0, 4'd0);
      obs = {cfg_ready, busy, div_out, period_done};
      checks++;
      if (obs !== 4'b0100) begin errors++; $display("FAIL restart_hold got=%b exp=0100", obs); end
      restart_in = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(0, 4'd0);
         obs = {cfg_ready, busy, div_out, period_done};
         checks++;
         if (obs !== {2'b11, 1'((i % 6) < 3), 1'((i % 6) == 5)}) begin
            errors++; $display("FAIL restart_fresh cyc=%0d got=%b exp=%b", i, obs, {2'b11, 1'((i % 6) < 3), 1'((i % 6) == 5)});
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_div4();
      test_change();
      test_stop();
      test_boundary();
      test_async_reset();
`ifdef CLKDIV_SCHED_RESTART_EN
      test_restart();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
